// File: rtl/io_dma_pkg.sv
// Shared FSM state type and the segmented-memory address map for io_dma and the mem decode.
package io_dma_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DUMP = 2'd2
    } state_t;

    localparam int IOBASE    = 1056;
    localparam int IOSIZE    = 512;
    localparam int STARTADDR = 1568;
    localparam int DONEADDR  = 1569;

endpackage

// File: rtl/io_dma.sv
// Streams a buffer into the I/O segment, lends the mem port to the CPU, then streams it back out.
// Latency: one word per cycle in LOAD/DUMP; RUN entered the edge after the last load beat, DUMP the edge after the done write.
// Backpressure: in_ready only in LOAD; out_data held while out_ready is low because widx only moves on a handshake.
module io_dma #(
    parameter int WIDTH    = 32,
    parameter int IOBASE   = io_dma_pkg::IOBASE,
    parameter int IOWORDS  = io_dma_pkg::IOSIZE,
    parameter int DONEADDR = io_dma_pkg::DONEADDR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_a,
    input  logic [WIDTH-1:0] cpu_wd,
    output logic [WIDTH-1:0] cpu_rd,
    output logic             busy,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_a,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd,
    output logic             startIO,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready
);
    import io_dma_pkg::*;

    localparam int IW = $clog2(IOWORDS);
    localparam int CW = IW + 1;
    localparam logic [IW-1:0] LASTIDX = IW'(IOWORDS - 1);

    state_t          state;
    logic [IW-1:0]   widx;
    logic [CW-1:0]   cnt;

    logic             load_hs;
    logic             load_end;
    logic             dump_hs;
    logic             dump_end;
    logic             done_wr;
    logic [WIDTH-1:0] io_addr;

    assign io_addr  = WIDTH'(IOBASE) + WIDTH'(widx);
    assign load_hs  = (state == LOAD) && in_valid;
    assign load_end = load_hs && (in_last || (widx == LASTIDX));
    assign dump_end = (state == DUMP) && ({1'b0, widx} == (cnt - CW'(1)));
    assign dump_hs  = (state == DUMP) && out_ready;
    assign done_wr  = (state == RUN) && cpu_we && (cpu_a == WIDTH'(DONEADDR));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
            widx  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (load_hs) begin
                        cnt <= {1'b0, widx} + CW'(1);
                        if (load_end) begin
                            state <= RUN;
                            widx  <= '0;
                        end else begin
                            widx  <= widx + IW'(1);
                        end
                    end
                end
                RUN: begin
                    if (done_wr) state <= DUMP;
                end
                DUMP: begin
                    if (dump_hs) begin
                        if (dump_end) begin
                            state <= LOAD;
                            widx  <= '0;
                        end else begin
                            widx  <= widx + IW'(1);
                        end
                    end
                end
                default: begin
                    state <= LOAD;
                    widx  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        cpu_rd    = '0;
        busy      = 1'b1;
        mem_we    = 1'b0;
        mem_a     = '0;
        mem_wd    = '0;
        startIO   = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                mem_we   = load_hs && !reset;
                mem_a    = io_addr;
                mem_wd   = in_data;
            end
            RUN: begin
                busy    = 1'b0;
                startIO = 1'b1;
                mem_we  = cpu_we;
                mem_a   = cpu_a;
                mem_wd  = cpu_wd;
                cpu_rd  = mem_rd;
            end
            DUMP: begin
                // The program's result flag stays visible until the last word leaves.
                startIO   = 1'b1;
                mem_a     = io_addr;
                out_valid = 1'b1;
                out_data  = mem_rd;
                out_last  = dump_end;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/io_dma.md
# io_dma

Host-side I/O loader/unloader that sits directly on the data port of the segmented memory, between the CPU's memory stage and `mem`. It streams an input buffer into the 512-word I/O segment, raises `startIO`, and hands the port to the CPU. When the CPU writes the done address, it streams the same number of words back out. The CPU may access memory only while the block is in RUN; the pipeline stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, 32, data/address width
- `IOBASE`, 1056, first word address of I/O segment
- `IOWORDS`, 512, I/O segment size (power of two)
- `DONEADDR`, 1569, CPU write to this address ends RUN (not backed by memory)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `cpu_we`  in  1  CPU data write enable
- `cpu_a`  in  WIDTH  CPU data address
- `cpu_wd`  in  WIDTH  CPU write data
- `cpu_rd`  out  WIDTH  read data to CPU
- `busy`  out  1  CPU must stall (high in every state except RUN)
- `mem_we`  out  1  to `mem` `we`
- `mem_a`  out  WIDTH  to `mem` `a2`
- `mem_wd`  out  WIDTH  to `mem` `wd`
- `mem_rd`  in  WIDTH  from `mem` `rd2` (combinational read)
- `startIO`  out  1  to `mem` `startIO`
- `in_valid`, `in_data[WIDTH]`, `in_last`  in  input stream
- `in_ready`  out  1  input stream ready
- `out_valid`, `out_data[WIDTH]`, `out_last`  out  output stream
- `out_ready`  in  1  output stream ready

## Operation
- States: LOAD (reset state), RUN, DUMP.
- Registers: `widx` (log2 IOWORDS bits), `cnt` (log2 IOWORDS+1 bits, range 1..IOWORDS), state.

**LOAD**
- `in_ready`=1 and `busy`=1.
- On a handshake: `mem_we`=1, `mem_a`=IOBASE+`widx`, `mem_wd`=`in_data`. Then `widx`++ and `cnt`=`widx`+1.
- Exit to RUN after the handshake carrying `in_last`, or after the handshake at `widx`=IOWORDS-1, whichever comes first. Beats past the limit are never accepted.
- `widx` clears on exit.

**RUN**
- `startIO`=1 and `busy`=0.
- `mem_we`/`mem_a`/`mem_wd` = `cpu_we`/`cpu_a`/`cpu_wd`, and `cpu_rd`=`mem_rd`.
- A write with `cpu_we`=1 and `cpu_a`=DONEADDR goes to DUMP; that write is also forwarded, and `mem` ignores it.
- Reads of 1568 return `startIO` through `mem`.

**DUMP**
- `busy`=1, `mem_we`=0, `mem_a`=IOBASE+`widx`.
- `out_valid`=1, `out_data`=`mem_rd`, `out_last`=(`widx`=`cnt`-1).
- On a handshake, `widx`++. The handshake with `out_last` returns to LOAD and clears `widx`.

**Outside RUN**
- `cpu_rd`=0 and CPU writes are dropped.
- `in_ready`=0 outside LOAD; `out_valid`=0 outside DUMP.
- `in_valid` and `out_ready` are ignored in states that do not use them.

## Timing
- Reset values: state LOAD, `widx`=0, `cnt`=0, `startIO`=0, `busy`=1, `in_ready`=1, `out_valid`=0, `out_last`=0, `mem_we`=0, `cpu_rd`=0.
- Reset asserted mid-LOAD, mid-RUN or mid-DUMP returns to LOAD on the next edge. Already-written memory is not cleared.
- Port outputs are combinational from state, counters and the current inputs. Only state, `widx` and `cnt` are registered.
- One word per cycle is sustained in LOAD and DUMP.
- `startIO` rises the cycle after the last load beat and falls the cycle after the final out handshake.
- The DONEADDR write has an exit latency of 1 cycle (DUMP starts next edge).
- `out_data` must be held stable while `out_valid`=1 and `out_ready`=0. This is guaranteed because `widx` does not move.
- A single-beat load (`in_last` on the first beat) gives `cnt`=1 and dumps exactly one word, with `out_last` on it.
- A full load of IOWORDS beats without `in_last` gives `cnt`=IOWORDS. `widx` wraps to 0 on exit with no overflow.
- If `in_last` arrives with `widx`=IOWORDS-1 simultaneously, it is a single exit event.

## Structure
- Package `io_dma_pkg` holds:
  - the `state_t` enum {LOAD, RUN, DUMP}
  - the address constants IOBASE, IOSIZE=512, STARTADDR=1568, DONEADDR=1569, shared with `mem` decode
- Single module; no sub-module needed. The FSM and two counters are one `always_ff` plus one `always_comb` port mux.

## Test plan
- **Three-word load:** load 3 words 0xA,0xB,0xC with `in_last` on the third → writes to 1056..1058; `startIO`=1 and `busy`=0 the next cycle.
- **CPU access in RUN:** in RUN, CPU reads 1057 → `cpu_rd`=0xB. CPU reads 1568 → 1. CPU writes 0x55 to 1058 → memory updated.
- **Dump with backpressure:** CPU writes DONEADDR → DUMP; `out_data` is 0xA,0xB,0x55 with `out_last` on the third; `out_ready` toggled 1/0 holds data stable; back to LOAD with `startIO`=0.
- **Full buffer:** 513 valid beats without `in_last` → exactly 512 accepted (`in_ready` low after); dump emits 512 words with `out_last` at index 511.
- **Reset mid-DUMP:** assert `reset` during DUMP after 2 beats → LOAD next cycle, `out_valid`=0, `widx`=0; a new 1-beat load dumps 1 word.
- **Stalled CPU:** CPU writes during LOAD/DUMP → `mem_we` is never driven by the CPU; `busy`=1 throughout.
